cache_fill_ctrl: RTL and testbench
==================================

# cache_fill_ctrl

Parametrised cache miss controller that replaces the fixed 8-word, 16-bit fill FSM. It sits between the cache tag-match logic and the memory port. On a miss it optionally writes back a dirty victim block, then streams a block-aligned fill from memory into the data array one word per returned beat, and finally writes the tag array. Memory latency is variable: returned words are counted, not timed.

## Interface
- `DATA_W`, 16, word width in bits; multiple of 8.
- `ADDR_W`, 16, byte address width.
- `WORDS`, 8, words per cache block; power of 2, ≥2.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; one clock domain.
- `miss_detected`  in  1  tag-match miss; sampled only in IDLE.
- `miss_address`  in  ADDR_W  byte address that missed.
- `victim_dirty`  in  1  victim block must be written back; sampled with the miss.
- `victim_address`  in  ADDR_W  any byte address inside the victim block; sampled with the miss.
- `cache_rd_data`  in  DATA_W  data-array read data for `word_sel`, combinational.
- `memory_data`  in  DATA_W  read data returned by memory.
- `memory_data_valid`  in  1  `memory_data` is valid this cycle.
- `fsm_busy`  out  1  stall request to the pipeline.
- `word_sel`  out  log2(WORDS)  word offset into the data array, used for both read and write.
- `write_data_array`  out  1  data-array write enable; data is `fill_data`.
- `fill_data`  out  DATA_W  equals `memory_data`.
- `write_tag_array`  out  1  tag and valid write enable; one-cycle pulse.
- `memory_address`  out  ADDR_W  memory word address.
- `mem_rd_en`  out  1  memory read request.
- `mem_wr_en`  out  1  memory write request.
- `mem_wr_data`  out  DATA_W  write-back data; equals `cache_rd_data`.

## Operation
- BPW = DATA_W/8 bytes per word. Block base = address with the low log2(WORDS·BPW) bits cleared. Word k address = base + k·BPW, computed modulo 2^ADDR_W.
- States: IDLE, WB, FILL, TAG.
- IDLE, `miss_detected`=1: latch both block bases. Go to WB if `victim_dirty`, otherwise go to FILL. Clear all counters.
- WB, one word per cycle, k = 0..WORDS-1:
  - `word_sel`=k, `memory_address`=victim base + k·BPW, `mem_wr_en`=1.
  - After k=WORDS-1, go to FILL.
- FILL:
  - Issue counter i: while i<WORDS, drive `mem_rd_en`=1 and `memory_address`=miss base + i·BPW, then increment i. One issue per cycle.
  - Receive counter r: on each `memory_data_valid`, `write_data_array`=1, `word_sel`=r, then increment r.
  - Memory returns in issue order.
  - When r reaches WORDS (on the cycle the last valid is accepted), go to TAG.
- TAG: `write_tag_array`=1 for one cycle, then go to IDLE.
- `fsm_busy` = (state≠IDLE) | `miss_detected`. This is combinational, so the pipeline stalls on the miss cycle.
- `memory_data_valid` outside FILL is ignored: no array write, no counter change.
- `miss_detected` outside IDLE is ignored.
- When not in WB or FILL-issue, `mem_rd_en`, `mem_wr_en` and `memory_address` are 0. When not in WB or on a valid beat, `word_sel` is 0.

## Timing
- Reset: state IDLE, counters 0, latched bases 0. All outputs 0, except `fsm_busy`, which follows `miss_detected`.
- Reset asserted mid-operation aborts immediately. No tag write occurs, and the partial block stays invalid.
- Miss at cycle 0 → first WB or FILL cycle at cycle 1.
- WB takes exactly WORDS cycles.
- Clean miss with fixed memory latency L (data for an issue at cycle t is valid at t+L):
  - reads issue at cycles 1..WORDS;
  - last write at WORDS+L;
  - TAG at WORDS+L+1;
  - IDLE, `fsm_busy`=0, at WORDS+L+2 unless a new miss is present.
- Valid concurrent with an issue (L small): both proceed in the same cycle.
- Back-to-back miss: a miss presented on the first IDLE cycle after TAG is accepted.

## Structure
- Package `cache_pkg`:
  - state enum `fill_state_t`;
  - helper localparams BPW and offset-bit count derived from DATA_W and WORDS.
- Sub-module `block_word_counter`, parametrised by WORDS:
  - inputs: clear, enable;
  - outputs: count and terminal flag;
  - async active-low reset.
- Three instances: WB, issue and receive counters.
- Address generation is base + (count << log2(BPW)).

## Test plan
- Clean miss, defaults, L=4, miss_address=0x1236:
  - reads at 0x1230..0x123E, cycles 1–8;
  - `write_data_array` cycles 5–12 with `word_sel` 0..7;
  - `write_tag_array` at cycle 13;
  - `fsm_busy` falls at cycle 14.
- Dirty miss, victim_address=0x4008, miss_address=0x0010:
  - `mem_wr_en` at 0x4000..0x400E with `mem_wr_data`=`cache_rd_data`, cycles 1–8;
  - then reads at 0x0010..0x001E starting cycle 9.
- Irregular latency, valid gaps of 0–3 cycles:
  - exactly 8 array writes in order 0..7;
  - tag pulse one cycle after the 8th valid.
- Spurious `memory_data_valid` in IDLE and WB, and `miss_detected` held high through FILL: no extra writes, no restart.
- Reset asserted in FILL after 3 words: all outputs 0 the same cycle; a following miss restarts at word 0.
- DATA_W=32, WORDS=4, miss_address=0xFFF8: reads at 0xFFF0, 0xFFF4, 0xFFF8, 0xFFFC; tag written after 4 valids.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the cache miss/fill controller.
// Block geometry is derived from word width and words-per-block.
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_FILL = 2'd2,
        ST_TAG  = 2'd3
    } fill_state_t;

    function automatic int unsigned bytes_per_word(input int unsigned data_w);
        return data_w / 32'd8;
    endfunction

    function automatic int unsigned block_offset_bits(input int unsigned data_w,
                                                      input int unsigned words);
        return $clog2(words * (data_w / 32'd8));
    endfunction

    localparam int unsigned DEF_DATA_W   = 32'd16;
    localparam int unsigned DEF_WORDS    = 32'd8;
    localparam int unsigned BPW          = bytes_per_word(DEF_DATA_W);
    localparam int unsigned OFF_BITS     = block_offset_bits(DEF_DATA_W, DEF_WORDS);

endpackage

// File: rtl/block_word_counter.sv
// Word index counter for one block transfer: clears to 0, steps on enable,
// wraps after the last word and flags the last word combinationally.
module block_word_counter #(
    parameter int unsigned WORDS = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       enable,
    output logic [$clog2(WORDS)-1:0]   count,
    output logic                       terminal
);

    localparam int unsigned   CW   = $clog2(WORDS);
    localparam logic [CW-1:0] LAST = CW'(WORDS - 32'd1);
    localparam logic [CW-1:0] ONE  = CW'(32'd1);

    logic [CW-1:0] count_r;

    // Word index register; clear has priority over stepping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            count_r <= {CW{1'b0}};
        end else if (enable) begin
            count_r <= count_r + ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count    = count_r;
    assign terminal = (count_r == LAST);

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache miss controller: optional dirty-victim write-back, block-aligned
// fill counted by returned beats (latency independent), then tag write.
module cache_fill_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned WORDS  = DEF_WORDS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       miss_detected,
    input  logic [ADDR_W-1:0]          miss_address,
    input  logic                       victim_dirty,
    input  logic [ADDR_W-1:0]          victim_address,
    input  logic [DATA_W-1:0]          cache_rd_data,
    input  logic [DATA_W-1:0]          memory_data,
    input  logic                       memory_data_valid,
    output logic                       fsm_busy,
    output logic [$clog2(WORDS)-1:0]   word_sel,
    output logic                       write_data_array,
    output logic [DATA_W-1:0]          fill_data,
    output logic                       write_tag_array,
    output logic [ADDR_W-1:0]          memory_address,
    output logic                       mem_rd_en,
    output logic                       mem_wr_en,
    output logic [DATA_W-1:0]          mem_wr_data
);

    localparam int unsigned       SEL_W         = $clog2(WORDS);
    localparam int unsigned       WORD_SHIFT    = $clog2(bytes_per_word(DATA_W));
    localparam int unsigned       BLK_OFF_BITS  = block_offset_bits(DATA_W, WORDS);
    localparam logic [ADDR_W-1:0] BASE_MASK     = {ADDR_W{1'b1}} << BLK_OFF_BITS;

    fill_state_t         state_r;
    fill_state_t         state_s;
    logic [ADDR_W-1:0]   miss_base_r;
    logic [ADDR_W-1:0]   victim_base_r;
    logic                iss_done_r;

    logic                cnt_clear_s;
    logic                wb_en_s;
    logic                iss_en_s;
    logic                rcv_en_s;
    logic [SEL_W-1:0]    wb_cnt_s;
    logic [SEL_W-1:0]    iss_cnt_s;
    logic [SEL_W-1:0]    rcv_cnt_s;
    logic                wb_last_s;
    logic                iss_last_s;
    logic                rcv_last_s;

    // Byte address of word k of a block; wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [SEL_W-1:0]  k);
        return base + (ADDR_W'(k) << WORD_SHIFT);
    endfunction

    block_word_counter #(.WORDS(WORDS)) u_wb_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear_s),
        .enable   (wb_en_s),
        .count    (wb_cnt_s),
        .terminal (wb_last_s)
    );

    block_word_counter #(.WORDS(WORDS)) u_iss_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear_s),
        .enable   (iss_en_s),
        .count    (iss_cnt_s),
        .terminal (iss_last_s)
    );

    block_word_counter #(.WORDS(WORDS)) u_rcv_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear_s),
        .enable   (rcv_en_s),
        .count    (rcv_cnt_s),
        .terminal (rcv_last_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Capture both block bases when a miss is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_base_r   <= {ADDR_W{1'b0}};
            victim_base_r <= {ADDR_W{1'b0}};
        end else if ((state_r == ST_IDLE) && miss_detected) begin
            miss_base_r   <= miss_address & BASE_MASK;
            victim_base_r <= victim_address & BASE_MASK;
        end else begin
            miss_base_r   <= miss_base_r;
            victim_base_r <= victim_base_r;
        end
    end

    // The issue counter wraps after its last word, so remember that all were issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_done_r <= 1'b0;
        end else if (cnt_clear_s) begin
            iss_done_r <= 1'b0;
        end else if (iss_en_s && iss_last_s) begin
            iss_done_r <= 1'b1;
        end else begin
            iss_done_r <= iss_done_r;
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        state_s          = state_r;
        cnt_clear_s      = 1'b0;
        wb_en_s          = 1'b0;
        iss_en_s         = 1'b0;
        rcv_en_s         = 1'b0;
        word_sel         = {SEL_W{1'b0}};
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        memory_address   = {ADDR_W{1'b0}};
        mem_rd_en        = 1'b0;
        mem_wr_en        = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (miss_detected) begin
                    cnt_clear_s = 1'b1;
                    state_s     = victim_dirty ? ST_WB : ST_FILL;
                end else begin
                    state_s     = ST_IDLE;
                end
            end
            ST_WB: begin
                mem_wr_en      = 1'b1;
                word_sel       = wb_cnt_s;
                memory_address = word_addr(victim_base_r, wb_cnt_s);
                wb_en_s        = 1'b1;
                if (wb_last_s) begin
                    state_s = ST_FILL;
                end else begin
                    state_s = ST_WB;
                end
            end
            ST_FILL: begin
                // Issue and receive are independent; both may act in one cycle.
                if (!iss_done_r) begin
                    mem_rd_en      = 1'b1;
                    memory_address = word_addr(miss_base_r, iss_cnt_s);
                    iss_en_s       = 1'b1;
                end else begin
                    mem_rd_en      = 1'b0;
                end
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    word_sel         = rcv_cnt_s;
                    rcv_en_s         = 1'b1;
                    if (rcv_last_s) begin
                        state_s = ST_TAG;
                    end else begin
                        state_s = ST_FILL;
                    end
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_TAG: begin
                write_tag_array = 1'b1;
                state_s         = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign fsm_busy    = (state_r != ST_IDLE) | miss_detected;
    assign fill_data   = memory_data;
    assign mem_wr_data = cache_rd_data;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Randomised self-checking bench for cache_fill_ctrl: default geometry plus a
// 32-bit, 4-word instance, checked cycle by cycle against a timeline model.
module tb_cache_fill_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [15:0] salt;

    // default instance: DATA_W=16, ADDR_W=16, WORDS=8
    logic        miss_detected, victim_dirty, memory_data_valid;
    logic [15:0] miss_address, victim_address, cache_rd_data, memory_data;
    logic        fsm_busy, write_data_array, write_tag_array, mem_rd_en, mem_wr_en;
    logic [2:0]  word_sel;
    logic [15:0] fill_data, memory_address, mem_wr_data;

    // wide instance: DATA_W=32, ADDR_W=16, WORDS=4
    logic        b_miss, b_dirty, b_valid;
    logic [15:0] b_maddr, b_vaddr;
    logic [31:0] b_rd_data, b_mem_data;
    logic        b_busy, b_wda, b_tag, b_rd_en, b_wr_en;
    logic [1:0]  b_sel;
    logic [31:0] b_fill, b_wr_data;
    logic [15:0] b_addr;

    assign cache_rd_data = salt ^ {13'd0, word_sel};
    assign b_rd_data     = 32'h0000_0000;

    cache_fill_ctrl dut (
        .clk(clk), .rst_n(rst_n), .miss_detected(miss_detected), .miss_address(miss_address),
        .victim_dirty(victim_dirty), .victim_address(victim_address), .cache_rd_data(cache_rd_data),
        .memory_data(memory_data), .memory_data_valid(memory_data_valid), .fsm_busy(fsm_busy),
        .word_sel(word_sel), .write_data_array(write_data_array), .fill_data(fill_data),
        .write_tag_array(write_tag_array), .memory_address(memory_address), .mem_rd_en(mem_rd_en),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data)
    );

    cache_fill_ctrl #(.DATA_W(32), .ADDR_W(16), .WORDS(4)) dut_wide (
        .clk(clk), .rst_n(rst_n), .miss_detected(b_miss), .miss_address(b_maddr),
        .victim_dirty(b_dirty), .victim_address(b_vaddr), .cache_rd_data(b_rd_data),
        .memory_data(b_mem_data), .memory_data_valid(b_valid), .fsm_busy(b_busy),
        .word_sel(b_sel), .write_data_array(b_wda), .fill_data(b_fill),
        .write_tag_array(b_tag), .memory_address(b_addr), .mem_rd_en(b_rd_en),
        .mem_wr_en(b_wr_en), .mem_wr_data(b_wr_data)
    );

    // One complete miss on the default instance. The model is a timeline:
    // write-back occupies cycles 1..8 when dirty, reads issue on 8 consecutive
    // cycles after that, beat k returns at due[k], tag follows the last beat.
    task automatic run_miss(input string name, input bit dirty, input logic [15:0] vaddr,
                            input logic [15:0] maddr, input bit rand_lat, input int lat,
                            input bit spurious, input bit hold_miss, input int tail);
        int due[8];
        int fs, tag_c, recv, issue_c, prev, lo;
        bit v, e_rd, e_wr;
        int e_sel;
        logic [15:0] vbase, mbase, ea, drv;
        logic [23:0] exp_v, act_v;
        salt  = 16'($urandom);
        vbase = 16'((int'(vaddr) / 16) * 16);
        mbase = 16'((int'(maddr) / 16) * 16);
        fs    = dirty ? 9 : 1;
        prev  = -1;
        for (int k = 0; k < 8; k++) begin
            issue_c = fs + k;
            if (rand_lat) begin
                lo     = (issue_c + 1 > prev + 1) ? issue_c + 1 : prev + 1;
                due[k] = lo + int'($urandom_range(3, 0));
            end else begin
                due[k] = issue_c + lat;
            end
            prev = due[k];
        end
        tag_c = due[7] + 1;
        recv  = 0;
        for (int c = 0; c <= tag_c + tail; c++) begin
            @(posedge clk); #1;
            miss_detected = (c == 0) || (hold_miss && c <= tag_c);
            if (c == 0) begin
                miss_address   = maddr;
                victim_address = vaddr;
                victim_dirty   = dirty;
            end else begin
                miss_address   = 16'($urandom);
                victim_address = 16'($urandom);
                victim_dirty   = 1'($urandom);
            end
            if (recv < 8) v = (due[recv] == c);
            else          v = 1'b0;
            drv = 16'($urandom);
            memory_data = drv;
            memory_data_valid = v || (spurious && (c < fs || c >= tag_c) && ($urandom_range(1, 0) == 1));
            @(negedge clk);
            e_wr  = dirty && (c >= 1) && (c <= 8);
            e_rd  = (c >= fs) && (c < fs + 8);
            if (e_wr)      ea = vbase + 16'((c - 1) * 2);
            else if (e_rd) ea = mbase + 16'((c - fs) * 2);
            else           ea = 16'h0000;
            e_sel = e_wr ? (c - 1) : (v ? recv : 0);
            exp_v = {(c <= tag_c), e_rd, e_wr, v, (c == tag_c), 3'(e_sel), ea};
            act_v = {fsm_busy, mem_rd_en, mem_wr_en, write_data_array, write_tag_array, word_sel, memory_address};
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL %s cycle %0d {busy,rd,wr,wda,tag,sel,addr}: got %h expected %h", name, c, act_v, exp_v);
            end
            if (e_wr) begin
                checks++;
                if (mem_wr_data !== (salt ^ 16'(c - 1))) begin
                    failures++;
                    $display("FAIL %s wb_data cycle %0d: got %h expected %h", name, c, mem_wr_data, salt ^ 16'(c - 1));
                end
            end
            if (v) begin
                checks++;
                if (fill_data !== drv) begin
                    failures++;
                    $display("FAIL %s fill_data cycle %0d: got %h expected %h", name, c, fill_data, drv);
                end
                recv++;
            end
        end
        miss_detected     = 1'b0;
        memory_data_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({fsm_busy, mem_rd_en, mem_wr_en, write_data_array, write_tag_array, word_sel, memory_address} !== 24'h0) begin
            failures++;
            $display("FAIL reset_idle: got busy=%b rd=%b wr=%b wda=%b tag=%b sel=%0d addr=%h expected all 0",
                     fsm_busy, mem_rd_en, mem_wr_en, write_data_array, write_tag_array, word_sel, memory_address);
        end
        miss_detected = 1'b1;
        b_miss        = 1'b1;
        #1;
        checks++;
        if ({fsm_busy, b_busy, mem_rd_en, mem_wr_en, write_tag_array, b_rd_en, b_tag} !== 7'b1100000) begin
            failures++;
            $display("FAIL reset_busy_follows_miss: got busy=%b wide_busy=%b rd=%b wr=%b tag=%b expected busy=1 others 0",
                     fsm_busy, b_busy, mem_rd_en, mem_wr_en, write_tag_array);
        end
        miss_detected = 1'b0;
        b_miss        = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    task automatic test_clean_miss();
        run_miss("clean_L4", 1'b0, 16'h0000, 16'h1236, 1'b0, 4, 1'b0, 1'b0, 2);
        run_miss("clean_L1", 1'b0, 16'h0000, 16'($urandom), 1'b0, 1, 1'b0, 1'b0, 2);
    endtask

    task automatic test_dirty_miss();
        run_miss("dirty", 1'b1, 16'h4008, 16'h0010, 1'b0, 2, 1'b0, 1'b0, 2);
    endtask

    task automatic test_irregular();
        for (int n = 0; n < 4; n++)
            run_miss("irregular", 1'($urandom), 16'($urandom), 16'($urandom), 1'b1, 0, 1'b0, 1'b0, 2);
    endtask

    task automatic test_spurious();
        run_miss("spurious", 1'b1, 16'($urandom), 16'($urandom), 1'b1, 0, 1'b1, 1'b1, 3);
    endtask

    task automatic test_back_to_back();
        run_miss("b2b_first", 1'b0, 16'h0000, 16'h3000, 1'b0, 2, 1'b0, 1'b0, 0);
        run_miss("b2b_second", 1'b1, 16'h5555, 16'h7777, 1'b1, 0, 1'b0, 1'b0, 2);
    endtask

    task automatic test_reset_mid_fill();
        // clean miss with latency 1: words 0,1,2 land on cycles 2,3,4
        for (int c = 0; c <= 4; c++) begin
            @(posedge clk); #1;
            miss_detected     = (c == 0);
            miss_address      = 16'h2468;
            victim_dirty      = 1'b0;
            memory_data_valid = (c >= 2);
            memory_data       = 16'($urandom);
            @(negedge clk);
            if (c == 4) begin
                checks++;
                if ({write_data_array, word_sel} !== 4'b1_010) begin
                    failures++;
                    $display("FAIL mid_fill_third_word: got wda=%b sel=%0d expected wda=1 sel=2", write_data_array, word_sel);
                end
            end
        end
        @(posedge clk); #1;
        memory_data_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fsm_busy, mem_rd_en, mem_wr_en, write_data_array, write_tag_array, word_sel, memory_address} !== 24'h0) begin
            failures++;
            $display("FAIL reset_abort: got busy=%b rd=%b wr=%b wda=%b tag=%b sel=%0d addr=%h expected all 0",
                     fsm_busy, mem_rd_en, mem_wr_en, write_data_array, write_tag_array, word_sel, memory_address);
        end
        @(posedge clk); #1;
        memory_data_valid = 1'b0;
        rst_n = 1'b1;
        run_miss("restart", 1'b0, 16'h0000, 16'h2468, 1'b0, 3, 1'b0, 1'b0, 2);
    endtask

    task automatic test_wide();
        int due[4];
        int tag_c, recv;
        bit v, e_rd;
        logic [31:0] d;
        logic [15:0] base, ea;
        logic [22:0] exp_v, act_v;
        base = 16'((32'hFFF8 / 16) * 16);
        for (int k = 0; k < 4; k++) due[k] = (1 + k) + 2;
        tag_c = due[3] + 1;
        recv  = 0;
        for (int c = 0; c <= tag_c + 1; c++) begin
            @(posedge clk); #1;
            b_miss  = (c == 0);
            b_maddr = (c == 0) ? 16'hFFF8 : 16'($urandom);
            b_dirty = 1'b0;
            if (recv < 4) v = (due[recv] == c);
            else          v = 1'b0;
            b_valid    = v;
            d          = $urandom;
            b_mem_data = d;
            @(negedge clk);
            e_rd  = (c >= 1) && (c <= 4);
            ea    = e_rd ? base + 16'((c - 1) * 4) : 16'h0000;
            exp_v = {(c <= tag_c), e_rd, 1'b0, v, (c == tag_c), 2'(v ? recv : 0), ea};
            act_v = {b_busy, b_rd_en, b_wr_en, b_wda, b_tag, b_sel, b_addr};
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL wide cycle %0d {busy,rd,wr,wda,tag,sel,addr}: got %h expected %h", c, act_v, exp_v);
            end
            if (v) begin
                checks++;
                if (b_fill !== d) begin
                    failures++;
                    $display("FAIL wide fill_data cycle %0d: got %h expected %h", c, b_fill, d);
                end
                recv++;
            end
        end
        b_miss  = 1'b0;
        b_valid = 1'b0;
    endtask

    initial begin
        rst_n             = 1'b0;
        salt              = 16'h0000;
        miss_detected     = 1'b0;
        miss_address      = 16'h0000;
        victim_dirty      = 1'b0;
        victim_address    = 16'h0000;
        memory_data       = 16'h0000;
        memory_data_valid = 1'b0;
        b_miss            = 1'b0;
        b_dirty           = 1'b0;
        b_maddr           = 16'h0000;
        b_vaddr           = 16'h0000;
        b_mem_data        = 32'h0000_0000;
        b_valid           = 1'b0;

        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_irregular();
        test_spurious();
        test_back_to_back();
        test_reset_mid_fill();
        test_wide();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
